// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with flush and stall/bubble counters.
// in_ready is registered, so out_ready never reaches the upstream handshake combinationally.
module pipe_stage_reg #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter bit KEEP_CH0 = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int DW = NCH * WIDTH;

    logic          m_valid;
    logic          s_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] s_data;
    logic [DW-1:0] flush_data;
    logic          accept;
    logic          fire;
    logic          m_open;

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    assign accept = in_valid & ~s_valid;
    assign fire   = m_valid & out_ready;
    assign m_open = ~m_valid | fire;

    // Flushed entry keeps the PC channel so the redirect target stays visible downstream.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        flush_data = '0;
        if (KEEP_CH0) begin
            flush_data[WIDTH-1:0] = in_data[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset too, because out_data must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= flush_data;
        end else if (m_open) begin
            // A valid skid entry blocks accept, so it is always the next entry in order.
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_data <= in_data;
                end
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
    end

    // Counters look at pre-edge state, so a flush cycle still counts by its own out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!m_valid && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (m_valid && !out_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, sequence, reset and saturation
// checks, plus random traffic compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int DW    = WIDTH * NCH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready_k, out_valid_k;
    logic [DW-1:0] out_data_k;
    logic [15:0]   stall_cnt_k, bubble_cnt_k;

    logic          in_ready_z, out_valid_z;
    logic [DW-1:0] out_data_z;
    logic [3:0]    stall_cnt_z, bubble_cnt_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(WIDTH), .NCH(NCH), .KEEP_CH0(1'b1), .CNT_W(16)) dut_k (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_k), .in_data(in_data),
        .out_valid(out_valid_k), .out_ready(out_ready), .out_data(out_data_k),
        .stall_cnt(stall_cnt_k), .bubble_cnt(bubble_cnt_k)
    );

    pipe_stage_reg #(.WIDTH(WIDTH), .NCH(NCH), .KEEP_CH0(1'b0), .CNT_W(4)) dut_z (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_z), .in_data(in_data),
        .out_valid(out_valid_z), .out_ready(out_ready), .out_data(out_data_z),
        .stall_cnt(stall_cnt_z), .bubble_cnt(bubble_cnt_z)
    );

    // Reference model: the stage is a FIFO of at most two entries; the head is what is shown.
    logic [DW-1:0] q[$];
    logic [DW-1:0] md_keep;
    logic [DW-1:0] md_zero;
    int            stall_total;
    int            bubble_total;

    typedef struct {
        logic          fl;
        logic          iv;
        logic          ordy;
        logic [DW-1:0] d;
        logic          ev;
        logic          eir;
        logic [DW-1:0] ed;
        int            es;
        int            eb;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [DW-1:0] mk(input int tag);
        logic [DW-1:0] r;
        for (int k = 0; k < NCH; k++) begin
            r[k*WIDTH +: WIDTH] = 32'hA000_0000 | (tag << 8) | k;
        end
        return r;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        md_keep      = '0;
        md_zero      = '0;
        stall_total  = 0;
        bubble_total = 0;
    endtask

    task automatic model_step(input logic fl, input logic iv, input logic ordy, input logic [DW-1:0] d);
        bit had;
        bit acc;
        had = (q.size() > 0);
        acc = iv && (q.size() < 2);
        if (!had) bubble_total++;
        else if (!ordy) stall_total++;
        if (fl) begin
            q.delete();
            md_keep = '0;
            md_keep[WIDTH-1:0] = d[WIDTH-1:0];
            md_zero = '0;
        end else begin
            if (had && ordy) void'(q.pop_front());
            if (acc) q.push_back(d);
            if (q.size() > 0) begin
                md_keep = q[0];
                md_zero = q[0];
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid_k",  DW'(out_valid_k),  DW'(q.size() > 0));
        check("in_ready_k",   DW'(in_ready_k),   DW'(q.size() < 2));
        check("out_data_k",   out_data_k,        md_keep);
        check("stall_cnt_k",  DW'(stall_cnt_k),  DW'(sat(stall_total, 65535)));
        check("bubble_cnt_k", DW'(bubble_cnt_k), DW'(sat(bubble_total, 65535)));
        check("out_valid_z",  DW'(out_valid_z),  DW'(q.size() > 0));
        check("in_ready_z",   DW'(in_ready_z),   DW'(q.size() < 2));
        check("out_data_z",   out_data_z,        md_zero);
        check("stall_cnt_z",  DW'(stall_cnt_z),  DW'(sat(stall_total, 15)));
        check("bubble_cnt_z", DW'(bubble_cnt_z), DW'(sat(bubble_total, 15)));
    endtask

    // Drive one cycle's inputs, advance the model on the edge, compare at the falling edge.
    task automatic cycle(input logic fl, input logic iv, input logic ordy, input logic [DW-1:0] d);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
        @(posedge clk);
        model_step(fl, iv, ordy, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},  DW'(out_valid_k) | DW'(out_valid_z), '0);
        check({tag, "_in_ready"},   DW'(in_ready_k & in_ready_z), DW'(1));
        check({tag, "_out_data_k"}, out_data_k, '0);
        check({tag, "_out_data_z"}, out_data_z, '0);
        check({tag, "_counters"},   DW'({stall_cnt_k, bubble_cnt_k, stall_cnt_z, bubble_cnt_z}), '0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] fd;
        fd = mk(99);
        fd[WIDTH-1:0] = 32'h0000_0100;

        // Stall, release, then build M=A/S=B and flush with out_ready=0 and in_valid=1.
        tbl[0] = '{1'b0, 1'b1, 1'b1, mk(0),  1'b1, 1'b1, mk(0),        0, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, mk(1),  1'b1, 1'b0, mk(0),        1, 1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, mk(2),  1'b1, 1'b0, mk(0),        2, 1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, mk(2),  1'b1, 1'b0, mk(0),        3, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, mk(3),  1'b1, 1'b1, mk(1),        3, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, mk(3),  1'b0, 1'b1, mk(1),        3, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, mk(10), 1'b1, 1'b1, mk(10),       3, 2};
        tbl[7] = '{1'b0, 1'b1, 1'b0, mk(11), 1'b1, 1'b0, mk(10),       4, 2};
        tbl[8] = '{1'b1, 1'b1, 1'b0, fd,     1'b0, 1'b1, DW'(32'h100), 5, 2};
        tbl[9] = '{1'b0, 1'b0, 1'b1, mk(12), 1'b0, 1'b1, DW'(32'h100), 5, 3};

        // Reset state, sampled between edges while rst_n is low.
        model_reset();
        #7;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].d);
            check($sformatf("vec%0d_out_valid", i), DW'(out_valid_k), DW'(tbl[i].ev));
            check($sformatf("vec%0d_in_ready", i),  DW'(in_ready_k),  DW'(tbl[i].eir));
            check($sformatf("vec%0d_out_data", i),  out_data_k,       tbl[i].ed);
            check($sformatf("vec%0d_stall", i),     DW'(stall_cnt_k),  DW'(tbl[i].es));
            check($sformatf("vec%0d_bubble", i),    DW'(bubble_cnt_k), DW'(tbl[i].eb));
            if (i >= 8) check($sformatf("vec%0d_flush_ch0_zero", i), out_data_z, '0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(15) == 0), 1'($urandom), ($urandom_range(3) != 0),
                  {$urandom, $urandom, $urandom, $urandom});
        end

        // Fill M and S, then assert reset between edges.
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, mk(20));
        cycle(1'b0, 1'b1, 1'b0, mk(21));
        check("midstall_s_full", DW'(in_ready_k), '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back sequence with out_ready=1; first accept on the first edge after release.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b1, 1'b1, mk(40 + k));
            check($sformatf("seq%0d_data", k),  out_data_k, mk(40 + k));
            check($sformatf("seq%0d_ready", k), DW'(in_ready_k & out_valid_k), DW'(1));
        end
        check("seq_bubble_frozen", DW'(bubble_cnt_k), DW'(1));

        // Saturation of the 4-bit counter while idle.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
        end
        check("sat_bubble_z", DW'(bubble_cnt_z), DW'(15));
        check("sat_bubble_k", DW'(bubble_cnt_k), DW'(20));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, bit width of one data channel.
REQ-002 SHALL provide parameter NCH, default 4, number of channels (legal 1..16); channel 0 is the PC channel.
REQ-003 SHALL provide parameter KEEP_CH0, default 1, meaning flush keeps channel 0 (PC); 0 means it is zeroed.
REQ-004 SHALL provide parameter CNT_W, default 16, width of the statistics counters.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1, synchronous kill of all held entries (taken jump/branch).
REQ-008 SHALL have port in_valid, input, 1, upstream entry present.
REQ-009 SHALL have port in_ready, output, 1, stage can accept an entry this cycle.
REQ-010 SHALL have port in_data, input, NCH*WIDTH, channel k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid, output, 1, out_data holds a live entry.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts; deassertion is a stall.
REQ-013 SHALL have port out_data, output, NCH*WIDTH, registered entry, same channel layout.
REQ-014 SHALL have port stall_cnt, output, CNT_W, number of cycles with out_valid=1 and out_ready=0.
REQ-015 SHALL have port bubble_cnt, output, CNT_W, number of cycles with out_valid=0.

Function
REQ-016 SHALL hold two entries: main M (drives out_valid/out_data) and skid S; in_ready SHALL equal NOT S.valid, taken from a register with no combinational path from out_ready.
REQ-017 An accept SHALL occur when in_valid and in_ready; a fire SHALL occur when out_valid and out_ready.
REQ-018 When M is empty or fires: if S is valid, M SHALL load S and S SHALL clear (or S SHALL load the accepted input); otherwise M SHALL load the accepted input.
REQ-019 When M is valid and does not fire, an accept SHALL load S; M SHALL hold unchanged (stall hold, no data loss).
REQ-020 Latency through an empty stage SHALL be exactly 1 cycle; sustained throughput SHALL be 1 entry/cycle while out_ready=1.
REQ-021 Entries SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-022 When M does not receive a new entry, its data SHALL hold its previous value, including while invalid.
REQ-023 On flush, the next edge SHALL clear M.valid and S.valid and discard any input presented that cycle; flush SHALL win over stall, accept and fire.
REQ-024 On flush, M channels 1..NCH-1 SHALL become 0; channel 0 SHALL take in_data channel 0 if KEEP_CH0=1, else 0.
REQ-025 After flush, in_ready SHALL be 1 on the following cycle.
REQ-026 stall_cnt and bubble_cnt SHALL each increment by 1 per qualifying cycle, saturating at all-ones with no wrap.
REQ-027 Counters SHALL sample pre-edge state: the flush cycle SHALL count per out_valid in that cycle.

Reset
REQ-028 While rst_n=0, M, S, out_valid, out_data, stall_cnt and bubble_cnt SHALL be 0 immediately (asynchronous), and in_ready SHALL be 1.
REQ-029 Release of rst_n SHALL be handled as synchronous to clk; the first accept SHALL be possible on the first rising edge after release.
REQ-030 Reset asserted mid-transfer SHALL drop all entries; no partial state SHALL survive.

Verification
REQ-031 Sequence test: WIDTH=32, NCH=4, out_ready=1, inject A0..A9 back-to-back -> each appears 1 cycle later in order; in_ready stays 1; bubble_cnt does not advance after the first entry.
REQ-032 Stall test: hold out_ready=0 for 3 cycles with in_valid=1 -> M holds A0; S captures A1; in_ready=0 from the next cycle; stall_cnt=3; after release, A0 then A1 fire with no loss.
REQ-033 Flush test: M=A, S=B, flush=1, in_data ch0=0x00000100 -> next cycle out_valid=0, out_data ch0=0x00000100, ch1..3=0, in_ready=1; with KEEP_CH0=0, ch0=0.
REQ-034 Simultaneous test: flush with out_ready=0 and in_valid=1 -> flush wins; no entry survives; the input is not accepted.
REQ-035 Saturation test: CNT_W=4, idle 20 cycles -> bubble_cnt stops at 15.
REQ-036 Reset test: assert rst_n=0 mid-stall between edges -> outputs 0 and in_ready=1 without waiting for a clock edge.
